res_st_issue: RTL and testbench

- Parametrised successor to the single-write, random-read reservation station in the Qu core.
- Holds up to DEPTH dispatched uops and captures operand results from NUM_CDB common-data-bus broadcasts (wakeup).
- Selects the oldest entry with both operands ready and presents it through a registered valid/ready issue port to the back-end.
- Sits between the front-end dispatch stage and the execution units.

---
 rtl/res_st_issue_if.sv | 47 ++++
 rtl/res_st_issue.sv | 193 +++++++++++++++++++
 tb/tb_res_st_issue.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/res_st_issue_if.sv
// Dispatch, result-broadcast and issue bundle of the reservation station.
// The master side is the dispatch/back-end environment and the slave side is
// the station.
interface res_st_issue_if #(
  parameter int DEPTH         = 8,
  parameter int TAG_WIDTH     = 6,
  parameter int DATA_WIDTH    = 32,
  parameter int PAYLOAD_WIDTH = 32,
  parameter int NUM_CDB       = 2
);
  logic                          alloc_valid;
  logic                          alloc_ready;
  logic [PAYLOAD_WIDTH-1:0]      alloc_payload;
  logic [TAG_WIDTH-1:0]          alloc_rd_tag;
  logic [TAG_WIDTH-1:0]          alloc_rs1_tag;
  logic [TAG_WIDTH-1:0]          alloc_rs2_tag;
  logic                          alloc_rs1_rdy;
  logic                          alloc_rs2_rdy;
  logic [DATA_WIDTH-1:0]         alloc_rs1_data;
  logic [DATA_WIDTH-1:0]         alloc_rs2_data;
  logic [NUM_CDB-1:0]            cdb_valid;
  logic [NUM_CDB*TAG_WIDTH-1:0]  cdb_tag;
  logic [NUM_CDB*DATA_WIDTH-1:0] cdb_data;
  logic                          issue_valid;
  logic                          issue_ready;
  logic [PAYLOAD_WIDTH-1:0]      issue_payload;
  logic [TAG_WIDTH-1:0]          issue_rd_tag;
  logic [DATA_WIDTH-1:0]         issue_rs1_data;
  logic [DATA_WIDTH-1:0]         issue_rs2_data;
  logic [$clog2(DEPTH):0]        occupancy;

  modport master (
    output alloc_valid, alloc_payload, alloc_rd_tag, alloc_rs1_tag, alloc_rs2_tag,
           alloc_rs1_rdy, alloc_rs2_rdy, alloc_rs1_data, alloc_rs2_data,
           cdb_valid, cdb_tag, cdb_data, issue_ready,
    input  alloc_ready, issue_valid, issue_payload, issue_rd_tag,
           issue_rs1_data, issue_rs2_data, occupancy
  );

  modport slave (
    input  alloc_valid, alloc_payload, alloc_rd_tag, alloc_rs1_tag, alloc_rs2_tag,
           alloc_rs1_rdy, alloc_rs2_rdy, alloc_rs1_data, alloc_rs2_data,
           cdb_valid, cdb_tag, cdb_data, issue_ready,
    output alloc_ready, issue_valid, issue_payload, issue_rd_tag,
           issue_rs1_data, issue_rs2_data, occupancy
  );
endinterface

// File: rtl/res_st_issue.sv
// Reservation station with CDB wakeup, oldest-ready select and a registered
// valid/ready issue port. Age order is kept in an age matrix:
// older[i][j] = 1 means entry i was allocated before entry j.
// Optional macro RES_ST_ISSUE_BYPASS_EN: a fully ready alloc goes straight into
// the issue register when nothing stored is eligible (1-cycle latency).
module res_st_issue #(
  parameter int DEPTH         = 8,
  parameter int TAG_WIDTH     = 6,
  parameter int DATA_WIDTH    = 32,
  parameter int PAYLOAD_WIDTH = 32,
  parameter int NUM_CDB       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  res_st_issue_if.slave    bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;

  typedef logic [TAG_WIDTH-1:0]  tag_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  function automatic logic cdb_hit(input tag_t tag, input logic [NUM_CDB-1:0] v,
                                   input logic [NUM_CDB*TAG_WIDTH-1:0] t);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < NUM_CDB; c++)
      if (v[c] && (tag != '0) && (t[c*TAG_WIDTH +: TAG_WIDTH] == tag)) hit = 1'b1;
    return hit;
  endfunction

  // Walk channels from the top down so the lowest matching channel wins.
  function automatic data_t cdb_pick(input tag_t tag, input logic [NUM_CDB-1:0] v,
                                     input logic [NUM_CDB*TAG_WIDTH-1:0] t,
                                     input logic [NUM_CDB*DATA_WIDTH-1:0] d);
    data_t res;
    res = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--)
      if (v[c] && (tag != '0) && (t[c*TAG_WIDTH +: TAG_WIDTH] == tag))
        res = d[c*DATA_WIDTH +: DATA_WIDTH];
    return res;
  endfunction

  logic [DEPTH-1:0]         ent_vld, ent_r1, ent_r2;
  logic [DEPTH-1:0]         older [DEPTH];
  logic [PAYLOAD_WIDTH-1:0] ent_pay [DEPTH];
  tag_t                     ent_rd [DEPTH];
  tag_t                     ent_t1 [DEPTH];
  tag_t                     ent_t2 [DEPTH];
  data_t                    ent_d1 [DEPTH];
  data_t                    ent_d2 [DEPTH];
  logic [OCC_W-1:0]         occ;

  logic                     iss_vld;
  logic [PAYLOAD_WIDTH-1:0] iss_pay;
  tag_t                     iss_rd;
  data_t                    iss_d1, iss_d2;

  logic [DEPTH-1:0]         elig, oldest, wk1, wk2;
  data_t                    wk1_d [DEPTH];
  data_t                    wk2_d [DEPTH];
  logic [IDX_W-1:0]         sel_idx, free_idx;
  logic                     sel_any, can_load, take_ent, bypass;
  logic                     alloc_rdy, alloc_fire, alloc_store;
  logic                     a_r1, a_r2;
  data_t                    a_d1, a_d2;

  assign alloc_rdy          = (occ != OCC_W'(DEPTH));
  assign bus.alloc_ready    = alloc_rdy;
  assign bus.occupancy      = occ;
  assign bus.issue_valid    = iss_vld;
  assign bus.issue_payload  = iss_pay;
  assign bus.issue_rd_tag   = iss_rd;
  assign bus.issue_rs1_data = iss_d1;
  assign bus.issue_rs2_data = iss_d2;

  // Wakeup match of every stored pending source against the broadcasts.
  always_comb begin
    wk1 = '0;
    wk2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wk1[i]   = ent_vld[i] && !ent_r1[i] && cdb_hit(ent_t1[i], bus.cdb_valid, bus.cdb_tag);
      wk2[i]   = ent_vld[i] && !ent_r2[i] && cdb_hit(ent_t2[i], bus.cdb_valid, bus.cdb_tag);
      wk1_d[i] = cdb_pick(ent_t1[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      wk2_d[i] = cdb_pick(ent_t2[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    end
  end

  // Oldest eligible entry and lowest free slot, from registered state only.
  always_comb begin
    elig     = ent_vld & ent_r1 & ent_r2;
    oldest   = '0;
    sel_idx  = '0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      oldest[i] = elig[i];
      for (int j = 0; j < DEPTH; j++)
        if ((j != i) && elig[j] && !older[i][j]) oldest[i] = 1'b0;
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (oldest[i])   sel_idx  = IDX_W'(i);
      if (!ent_vld[i]) free_idx = IDX_W'(i);
    end
    sel_any = |elig;
  end

  // Alloc-time wakeup of the incoming sources and issue-load decision.
  always_comb begin
    alloc_fire = bus.alloc_valid && alloc_rdy;
    a_r1 = bus.alloc_rs1_rdy || cdb_hit(bus.alloc_rs1_tag, bus.cdb_valid, bus.cdb_tag);
    a_r2 = bus.alloc_rs2_rdy || cdb_hit(bus.alloc_rs2_tag, bus.cdb_valid, bus.cdb_tag);
    a_d1 = bus.alloc_rs1_rdy ? bus.alloc_rs1_data
         : cdb_pick(bus.alloc_rs1_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    a_d2 = bus.alloc_rs2_rdy ? bus.alloc_rs2_data
         : cdb_pick(bus.alloc_rs2_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    can_load = !iss_vld || bus.issue_ready;
    take_ent = can_load && sel_any;
`ifdef RES_ST_ISSUE_BYPASS_EN
    bypass = alloc_fire && a_r1 && a_r2 && can_load && !sel_any;
`else
    bypass = 1'b0;
`endif
    alloc_store = alloc_fire && !bypass;
  end

  // Control state: entry valid/ready bits, age matrix, occupancy, issue register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_vld <= '0;
      ent_r1  <= '0;
      ent_r2  <= '0;
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
      occ     <= '0;
      iss_vld <= 1'b0;
      iss_pay <= '0;
      iss_rd  <= '0;
      iss_d1  <= '0;
      iss_d2  <= '0;
    end else if (flush) begin
      ent_vld <= '0;
      occ     <= '0;
      iss_vld <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wk1[i]) ent_r1[i] <= 1'b1;
        if (wk2[i]) ent_r2[i] <= 1'b1;
      end
      if (take_ent) ent_vld[sel_idx] <= 1'b0;
      if (alloc_store) begin
        ent_vld[free_idx] <= 1'b1;
        ent_r1[free_idx]  <= a_r1;
        ent_r2[free_idx]  <= a_r2;
        for (int j = 0; j < DEPTH; j++) begin
          older[j][free_idx] <= 1'b1;
          older[free_idx][j] <= 1'b0;
        end
      end
      if (take_ent) begin
        iss_vld <= 1'b1;
        iss_pay <= ent_pay[sel_idx];
        iss_rd  <= ent_rd[sel_idx];
        iss_d1  <= ent_d1[sel_idx];
        iss_d2  <= ent_d2[sel_idx];
      end else if (bypass) begin
        iss_vld <= 1'b1;
        iss_pay <= bus.alloc_payload;
        iss_rd  <= bus.alloc_rd_tag;
        iss_d1  <= a_d1;
        iss_d2  <= a_d2;
      end else if (bus.issue_ready) begin
        iss_vld <= 1'b0;
      end
      occ <= occ + OCC_W'(alloc_store) - OCC_W'(take_ent);
    end
  end

  // Entry payload and operand storage; only meaningful under the valid bits.
  always_ff @(posedge clk) begin
    if (alloc_store) begin
      ent_pay[free_idx] <= bus.alloc_payload;
      ent_rd[free_idx]  <= bus.alloc_rd_tag;
      ent_t1[free_idx]  <= bus.alloc_rs1_tag;
      ent_t2[free_idx]  <= bus.alloc_rs2_tag;
      ent_d1[free_idx]  <= a_d1;
      ent_d2[free_idx]  <= a_d2;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (wk1[i]) ent_d1[i] <= wk1_d[i];
      if (wk2[i]) ent_d2[i] <= wk2_d[i];
    end
  end
endmodule

// File: tb/tb_res_st_issue.sv
// Bench for res_st_issue: directed scenarios plus a random phase, all checked
// against a queue-based age-ordered reference model.
module tb_res_st_issue;
  localparam int DEPTH = 8, TW = 6, DW = 32, PW = 32, NC = 2;
`ifdef RES_ST_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, flush;

  res_st_issue_if #(.DEPTH(DEPTH), .TAG_WIDTH(TW), .DATA_WIDTH(DW),
                    .PAYLOAD_WIDTH(PW), .NUM_CDB(NC)) bus();

  res_st_issue #(.DEPTH(DEPTH), .TAG_WIDTH(TW), .DATA_WIDTH(DW),
                 .PAYLOAD_WIDTH(PW), .NUM_CDB(NC))
    dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: stored uops in allocation order plus the issue register.
  typedef struct {
    logic [PW-1:0] pay;
    logic [TW-1:0] rd, t1, t2;
    bit            r1, r2;
    logic [DW-1:0] d1, d2;
  } ent_t;
  ent_t          q[$];
  bit            mv;
  logic [PW-1:0] mpay;
  logic [TW-1:0] mrd;
  logic [DW-1:0] md1, md2;

  logic [PW-1:0] log_pay[$];
  logic [DW-1:0] log_d1[$], log_d2[$];

  function automatic bit m_hit(input logic [TW-1:0] tag, output logic [DW-1:0] d);
    d = '0;
    if (tag == '0) return 1'b0;
    for (int c = 0; c < NC; c++)
      if (bus.cdb_valid[c] && bus.cdb_tag[c*TW +: TW] == tag) begin
        d = bus.cdb_data[c*DW +: DW];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic model_reset();
    q.delete();
    mv = 1'b0;
  endtask

  task automatic model_step();
    ent_t na, e, se;
    int sel;
    bit can_load, alloc_ok, byp;
    logic [DW-1:0] d;
    if (flush) begin
      model_reset();
      return;
    end
    can_load = !mv || bus.issue_ready;
    sel = -1;
    for (int k = 0; k < q.size(); k++)
      if (q[k].r1 && q[k].r2) begin sel = k; break; end
    na.pay = bus.alloc_payload; na.rd = bus.alloc_rd_tag;
    na.t1 = bus.alloc_rs1_tag;  na.t2 = bus.alloc_rs2_tag;
    na.r1 = bus.alloc_rs1_rdy;  na.r2 = bus.alloc_rs2_rdy;
    na.d1 = bus.alloc_rs1_data; na.d2 = bus.alloc_rs2_data;
    if (!na.r1 && m_hit(na.t1, d)) begin na.r1 = 1'b1; na.d1 = d; end
    if (!na.r2 && m_hit(na.t2, d)) begin na.r2 = 1'b1; na.d2 = d; end
    alloc_ok = bus.alloc_valid && (q.size() < DEPTH);
    byp = BYP && alloc_ok && na.r1 && na.r2 && can_load && (sel < 0);
    if (sel >= 0) se = q[sel];
    for (int k = 0; k < q.size(); k++) begin
      e = q[k];
      if (!e.r1 && m_hit(e.t1, d)) begin e.r1 = 1'b1; e.d1 = d; end
      if (!e.r2 && m_hit(e.t2, d)) begin e.r2 = 1'b1; e.d2 = d; end
      q[k] = e;
    end
    if (can_load && sel >= 0) begin
      mv = 1'b1; mpay = se.pay; mrd = se.rd; md1 = se.d1; md2 = se.d2;
      q.delete(sel);
    end else if (byp) begin
      mv = 1'b1; mpay = na.pay; mrd = na.rd; md1 = na.d1; md2 = na.d2;
    end else if (bus.issue_ready) begin
      mv = 1'b0;
    end
    if (alloc_ok && !byp) q.push_back(na);
  endtask

  task automatic check_outputs();
    chk("issue_valid", bus.issue_valid, mv);
    chk("occupancy", bus.occupancy, q.size());
    chk("alloc_ready", bus.alloc_ready, q.size() != DEPTH);
    if (mv) begin
      chk("issue_payload", bus.issue_payload, mpay);
      chk("issue_rd_tag", bus.issue_rd_tag, mrd);
      chk("issue_rs1", bus.issue_rs1_data, md1);
      chk("issue_rs2", bus.issue_rs2_data, md2);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (bus.issue_valid && bus.issue_ready) begin
      log_pay.push_back(bus.issue_payload);
      log_d1.push_back(bus.issue_rs1_data);
      log_d2.push_back(bus.issue_rs2_data);
    end
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    bus.alloc_valid = 1'b0;
    bus.cdb_valid   = '0;
    flush           = 1'b0;
  endtask

  task automatic set_alloc(input logic [PW-1:0] pay, input logic [TW-1:0] rd,
                           input logic [TW-1:0] t1, input bit r1, input logic [DW-1:0] d1,
                           input logic [TW-1:0] t2, input bit r2, input logic [DW-1:0] d2);
    bus.alloc_valid = 1'b1;
    bus.alloc_payload = pay; bus.alloc_rd_tag = rd;
    bus.alloc_rs1_tag = t1;  bus.alloc_rs1_rdy = r1; bus.alloc_rs1_data = d1;
    bus.alloc_rs2_tag = t2;  bus.alloc_rs2_rdy = r2; bus.alloc_rs2_data = d2;
  endtask

  task automatic clear_log();
    log_pay.delete(); log_d1.delete(); log_d2.delete();
  endtask

  logic [PW-1:0] snap;

  initial begin
    rst = 1'b1; flush = 1'b0; bus.issue_ready = 1'b1;
    set_alloc('0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    idle();
    bus.cdb_tag = '0; bus.cdb_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", bus.issue_valid, 0);
    chk("rst_occ", bus.occupancy, 0);
    chk("rst_ardy", bus.alloc_ready, 1);
    chk("rst_pay", bus.issue_payload, 0);
    chk("rst_rd", bus.issue_rd_tag, 0);
    chk("rst_rs1", bus.issue_rs1_data, 0);
    chk("rst_rs2", bus.issue_rs2_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // Ready-at-dispatch uop: 2-cycle latency (1 with bypass).
    clear_log();
    set_alloc(32'hA5, 6'd5, 6'd1, 1'b1, 32'h11, 6'd2, 1'b1, 32'h22);
    cycle();
    idle();
    chk("t1_after_alloc", bus.issue_valid, BYP);
    cycle();
    chk("t1_after_next", bus.issue_valid, !BYP);
    repeat (2) cycle();
    chk("t1_count", log_pay.size(), 1);
    chk("t1_pay", log_pay[0], 32'hA5);
    chk("t1_rs1", log_d1[0], 32'h11);
    chk("t1_rs2", log_d2[0], 32'h22);
    chk("t1_occ", bus.occupancy, 0);

    // Wakeup through CDB channel 1.
    clear_log();
    set_alloc(32'hB2, 6'd6, 6'd9, 1'b0, 32'h0, 6'd0, 1'b1, 32'h33);
    cycle();
    idle();
    repeat (1) cycle();
    bus.cdb_valid = 2'b10;
    bus.cdb_tag   = {TW'(9), TW'(0)};
    bus.cdb_data  = {32'hDEAD, 32'h0};
    cycle();
    idle();
    chk("t2_not_yet", bus.issue_valid, 0);
    cycle();
    chk("t2_valid", bus.issue_valid, 1);
    chk("t2_rs1", bus.issue_rs1_data, 32'hDEAD);
    repeat (2) cycle();

    // Fill, overflow attempt, then one broadcast releases all in age order.
    clear_log();
    for (int k = 0; k < DEPTH; k++) begin
      set_alloc(32'h100 + k, TW'(k), 6'd3, 1'b0, 32'h0, 6'd0, 1'b1, 32'(k));
      cycle();
    end
    idle();
    chk("t3_full_occ", bus.occupancy, DEPTH);
    chk("t3_full_ardy", bus.alloc_ready, 0);
    set_alloc(32'h1FF, 6'd1, 6'd1, 1'b1, 32'h0, 6'd1, 1'b1, 32'h0);
    cycle();
    idle();
    chk("t3_ignored_occ", bus.occupancy, DEPTH);
    bus.cdb_valid = 2'b01;
    bus.cdb_tag   = {TW'(0), TW'(3)};
    bus.cdb_data  = {32'h0, 32'h77};
    cycle();
    idle();
    repeat (12) cycle();
    chk("t3_count", log_pay.size(), DEPTH);
    for (int k = 0; k < DEPTH; k++)
      chk($sformatf("t3_order%0d", k),
          (k < log_pay.size()) ? log_pay[k] : 32'hFFFF_FFFF, 32'h100 + k);

    // Broadcast in the same cycle as the alloc that waits on it.
    clear_log();
    set_alloc(32'hC4, 6'd4, 6'd0, 1'b1, 32'h1, 6'd7, 1'b0, 32'h0);
    bus.cdb_valid = 2'b01;
    bus.cdb_tag   = {TW'(0), TW'(7)};
    bus.cdb_data  = {32'h0, 32'h55};
    cycle();
    idle();
    repeat (4) cycle();
    chk("t4_count", log_pay.size(), 1);
    chk("t4_rs2", log_d2.size() > 0 ? log_d2[0] : 32'hFFFF_FFFF, 32'h55);

    // Back-pressure holds the issue outputs; release drains in age order.
    clear_log();
    bus.issue_ready = 1'b0;
    set_alloc(32'hD0, 6'd1, 6'd0, 1'b1, 32'hD0, 6'd0, 1'b1, 32'hD0);
    cycle();
    set_alloc(32'hD1, 6'd2, 6'd0, 1'b1, 32'hD1, 6'd0, 1'b1, 32'hD1);
    cycle();
    idle();
    cycle();
    chk("t5_valid", bus.issue_valid, 1);
    snap = bus.issue_payload;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t5_hold", bus.issue_payload, snap);
    end
    bus.issue_ready = 1'b1;
    repeat (4) cycle();
    chk("t5_count", log_pay.size(), 2);
    chk("t5_first", log_pay.size() > 0 ? log_pay[0] : 32'hFFFF_FFFF, 32'hD0);
    chk("t5_second", log_pay.size() > 1 ? log_pay[1] : 32'hFFFF_FFFF, 32'hD1);

    // Flush wins over a simultaneous alloc.
    clear_log();
    bus.issue_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_alloc(32'hE0 + k, 6'd3, 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 32'h0);
      cycle();
    end
    idle();
    cycle();
    chk("t6_occ_before", bus.occupancy, 3);
    chk("t6_vld_before", bus.issue_valid, 1);
    set_alloc(32'hE9, 6'd3, 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 32'h0);
    flush = 1'b1;
    cycle();
    idle();
    chk("t6_occ_after", bus.occupancy, 0);
    chk("t6_vld_after", bus.issue_valid, 0);
    bus.issue_ready = 1'b1;
    repeat (4) cycle();
    chk("t6_nothing_issued", log_pay.size(), 0);

    // Random traffic with a mid-run asynchronous reset.
    for (int it = 0; it < 1500; it++) begin
      if (it == 700) begin
        rst = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_occ", bus.occupancy, 0);
        chk("mid_rst_vld", bus.issue_valid, 0);
        chk("mid_rst_ardy", bus.alloc_ready, 1);
        #1 rst = 1'b0;
      end
      set_alloc($urandom, TW'($urandom_range(0, 63)),
                TW'($urandom_range(1, 7)), ($urandom % 3) == 0, $urandom,
                TW'($urandom_range(1, 7)), ($urandom % 3) == 0, $urandom);
      bus.alloc_valid = ($urandom % 3) != 0;
      bus.cdb_valid   = NC'($urandom);
      bus.cdb_tag     = {TW'($urandom_range(0, 7)), TW'($urandom_range(0, 7))};
      bus.cdb_data    = {$urandom, $urandom};
      bus.issue_ready = ($urandom % 4) != 0;
      flush           = ($urandom % 64) == 0;
      cycle();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
